rr_arb_mux: RTL

Parametrised N-way, WIDTH-bit arbitrating multiplexer with a registered, handshaked output. It generalises the fixed 2:1/4:1 selectors to any channel count and width. Selection comes either from a fair round-robin arbiter or from a fixed select input. Its intended use is merging requesters onto one shared path, for example instruction fetch and load/store onto a single memory port. It sits between the requesting pipeline stages and the shared consumer.

---
 rtl/rr_arb_mux.sv | 105 ++++++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-way round-robin / fixed-select arbitrating mux with registered handshaked output
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid[N]           per-channel request
//   in_data[N*WIDTH]      flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready[N]           per-channel accept (combinational, one-hot or zero)
//   fix_en, fix_sel       fixed-select mode enable and channel index
//   out_valid/out_data/out_sel/out_ready  registered output word and its source channel
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic               fix_en,
  input  logic [SW-1:0]      fix_sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  input  logic               out_ready
);

  // Pad channel vectors to a power of two so any SW-bit index is in range;
  // padded channels never request and carry zero data.
  localparam int NP = 2 ** SW;

  logic [NP-1:0]    valid_pad;
  logic [WIDTH-1:0] ch_data [NP];
  logic [SW-1:0]    ptr;
  logic             load;
  logic             granted;
  logic [SW-1:0]    gidx;
  logic [N-1:0]     grant;
  int               sum;
  logic [SW-1:0]    idx;

  assign valid_pad = NP'(in_valid);

  for (genvar i = 0; i < NP; i++) begin : g_ch
    if (i < N) begin : g_real
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_data[i] = '0;
    end
  end

  // Output register can take a word when empty or being drained this cycle.
  assign load = !out_valid || out_ready;

  always_comb begin
    granted = 1'b0;
    gidx    = '0;
    sum     = 0;
    idx     = '0;
    if (fix_en) begin
      // Only fix_sel is examined, so other channels' valids never matter.
      if ((int'(fix_sel) < N) && valid_pad[fix_sel]) begin
        granted = 1'b1;
        gidx    = fix_sel;
      end
    end else begin
      // Scan ptr, ptr+1, ... wrapping at N-1 -> 0; first valid wins.
      for (int k = 0; k < N; k++) begin
        sum = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        idx = SW'(sum);
        if (!granted && valid_pad[idx]) begin
          granted = 1'b1;
          gidx    = idx;
        end
      end
    end
    grant = granted ? (N'(1) << gidx) : '0;
  end

  assign in_ready = (rst_n && load) ? grant : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (granted) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gidx];
        out_sel   <= gidx;
        // Fixed-mode transfers leave the round-robin position untouched.
        if (!fix_en) begin
          ptr <= (int'(gidx) == N - 1) ? '0 : gidx + SW'(1);
        end
      end else begin
        // Empty cycle: data/sel keep their last values.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
